upe_sum3_accum: RTL and testbench

- Sequential accumulator that consumes triples of 64-bit unsigned terms and accumulates Σ(A+B+C) over a run of samples.
- Sits directly downstream of the term generators and feeds the final uncertainty result register.
- Performs the 64-bit three-operand-plus-accumulator add as two chained 32-bit half-adds (lo then hi) with an explicit inter-half carry, one half per cycle.
- Valid/ready handshake on input and output.

---
 rtl/upe_sum3_accum_if.sv | 26 ++
 rtl/upe_sum3_accum.sv | 118 +++++++++++
 tb/tb_upe_sum3_accum.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/upe_sum3_accum_if.sv
// Handshake bundle for the three-term accumulator: triple input side and run-result output side.
interface upe_sum3_accum_if #(
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        A;
  logic [63:0]        B;
  logic [63:0]        C;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        Out;
  logic [COUNT_W-1:0] out_count;
  logic               overflow;

  modport master (
    output in_valid, A, B, C, in_last, out_ready,
    input  in_ready, out_valid, Out, out_count, overflow
  );

  modport slave (
    input  in_valid, A, B, C, in_last, out_ready,
    output in_ready, out_valid, Out, out_count, overflow
  );
endinterface

// File: rtl/upe_sum3_accum.sv
// Accumulates sum(A+B+C) over a run of triples using two chained 32-bit half-adds,
// one half per cycle, with a sticky overflow flag and a saturating triple counter.
module upe_sum3_accum #(
  parameter int COUNT_W = 8
) (
  input logic             clk,
  input logic             reset,
  upe_sum3_accum_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADD_LO, ADD_HI, DONE} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [63:0]        a_q, a_d, b_q, b_d, c_q, c_d;
  logic               last_q, last_d;
  logic [63:0]        acc_q, acc_d;
  logic [1:0]         carry_q, carry_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [33:0]        lo_sum, hi_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ADD_LO;
      ADD_LO:  state_d = ADD_HI;
      ADD_HI:  state_d = last_q ? DONE : IDLE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.Out       = acc_q;
    bus.out_count = cnt_q;
    bus.overflow  = ovf_q;
  end

  // Lo-half carry can reach 3 (four 32-bit operands), so it is two bits wide.
  always_comb begin
    lo_sum = {2'b00, acc_q[31:0]} + {2'b00, a_q[31:0]}
           + {2'b00, b_q[31:0]} + {2'b00, c_q[31:0]};
    hi_sum = {2'b00, acc_q[63:32]} + {2'b00, a_q[63:32]}
           + {2'b00, b_q[63:32]} + {2'b00, c_q[63:32]} + {32'd0, carry_q};
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    last_d  = last_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d    = bus.A;
          b_d    = bus.B;
          c_d    = bus.C;
          last_d = bus.in_last;
        end
      end
      ADD_LO: begin
        acc_d[31:0] = lo_sum[31:0];
        carry_d     = lo_sum[33:32];
      end
      ADD_HI: begin
        acc_d[63:32] = hi_sum[31:0];
        if (hi_sum[33:32] != 2'b00) ovf_d = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_upe_sum3_accum.sv
// Directed bench for upe_sum3_accum: two instances (COUNT_W=8 and COUNT_W=2) share one stimulus,
// and run results are predicted by a full-width reference sum held in a scoreboard queue.
module tb_upe_sum3_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        drv_valid, drv_last, drv_oready;
  logic [63:0] drv_a, drv_b, drv_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] out;
    int          n;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  logic [63:0] acc_m;
  int          n_m;
  logic        ovf_m;

  upe_sum3_accum_if #(.COUNT_W(8)) if8 ();
  upe_sum3_accum_if #(.COUNT_W(2)) if2 ();

  assign if8.in_valid  = drv_valid;
  assign if8.A         = drv_a;
  assign if8.B         = drv_b;
  assign if8.C         = drv_c;
  assign if8.in_last   = drv_last;
  assign if8.out_ready = drv_oready;
  assign if2.in_valid  = drv_valid;
  assign if2.A         = drv_a;
  assign if2.B         = drv_b;
  assign if2.C         = drv_c;
  assign if2.in_last   = drv_last;
  assign if2.out_ready = drv_oready;

  upe_sum3_accum #(.COUNT_W(8)) dut   (.clk(clk), .reset(reset), .bus(if8));
  upe_sum3_accum #(.COUNT_W(2)) dut_s (.clk(clk), .reset(reset), .bus(if2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    acc_m = '0;
    n_m   = 0;
    ovf_m = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the hi half completes.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic last);
    bit          ok = 1'b0;
    logic [65:0] s;
    exp_t        e;
    drv_valid = 1'b1;
    drv_a = a; drv_b = b; drv_c = c; drv_last = last;
    for (int i = 0; i < 40; i++) begin
      if (if8.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept_wait", 64'(ok), 64'd1);
    if (!ok) return;
    @(posedge clk);
    s = {2'b00, acc_m} + {2'b00, a} + {2'b00, b} + {2'b00, c};
    if (s[65:64] != 2'b00) ovf_m = 1'b1;
    acc_m = s[63:0];
    n_m++;
    if (last) begin
      e.out = acc_m; e.n = n_m; e.ovf = ovf_m;
      sb.push_back(e);
    end
    #1 drv_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("latency_out_valid", 64'(if8.out_valid), 64'(last));
    chk("latency_in_ready", 64'(if8.in_ready), 64'(!last));
  endtask

  // Waits for a result, holds out_ready low for 'hold' cycles, then completes the handshake.
  task automatic take(input int hold);
    bit   ok = 1'b0;
    exp_t e;
    int   c8, c2;
    drv_oready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if8.out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("out_valid_wait", 64'(ok), 64'd1);
    chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (!ok || sb.size() == 0) return;
    e  = sb.pop_front();
    c8 = (e.n > 255) ? 255 : e.n;
    c2 = (e.n > 3) ? 3 : e.n;
    for (int i = 0; i <= hold; i++) begin
      chk("out", if8.Out, e.out);
      chk("out_count", 64'(if8.out_count), 64'(c8));
      chk("overflow", 64'(if8.overflow), 64'(e.ovf));
      chk("out_count_w2", 64'(if2.out_count), 64'(c2));
      chk("out_w2", if2.Out, e.out);
      chk("out_valid_hold", 64'(if8.out_valid), 64'd1);
      chk("in_ready_done", 64'(if8.in_ready), 64'd0);
      if (i < hold) @(negedge clk);
    end
    drv_oready = 1'b1;
    @(posedge clk);
    #1 drv_oready = 1'b0;
    @(negedge clk);
    chk("post_out_valid", 64'(if8.out_valid), 64'd0);
    chk("post_out", if8.Out, 64'd0);
    chk("post_count", 64'(if8.out_count), 64'd0);
    chk("post_overflow", 64'(if8.overflow), 64'd0);
    chk("post_in_ready", 64'(if8.in_ready), 64'd1);
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drv_valid = 1'b0; drv_last = 1'b0; drv_oready = 1'b0;
    drv_a = '0; drv_b = '0; drv_c = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(if8.out_valid), 64'd0);
    chk("rst_out", if8.Out, 64'd0);
    chk("rst_count", 64'(if8.out_count), 64'd0);
    chk("rst_overflow", 64'(if8.overflow), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(if8.in_ready), 64'd1);

    // Single triple run
    send(64'd1, 64'd2, 64'd3, 1'b1);
    chk("single_out_const", if8.Out, 64'd6);
    take(0);

    // Lo-half carry of 3 into the hi half
    send(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    chk("acc_after_t1", if8.Out, 64'h2_FFFF_FFFD);
    send(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    send(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1);
    chk("carry3_out_const", if8.Out, 64'h8_FFFF_FFF7);
    take(0);

    // Overflow, then cleared on the following run
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 1'b1);
    chk("ovf_out_const", if8.Out, 64'd1);
    chk("ovf_flag_const", 64'(if8.overflow), 64'd1);
    take(0);
    send(64'd5, 64'd0, 64'd0, 1'b1);
    take(0);

    // Backpressure with a new triple waiting upstream
    send(64'd10, 64'd20, 64'd30, 1'b1);
    drv_valid = 1'b1; drv_a = 64'd9; drv_b = 64'd0; drv_c = 64'd0; drv_last = 1'b1;
    take(10);
    send(64'd9, 64'd0, 64'd0, 1'b1);
    take(0);

    // Reset during ADD_HI of the second triple of a run
    send(64'd7, 64'd0, 64'd0, 1'b0);
    drv_valid = 1'b1; drv_a = 64'd1; drv_b = 64'd1; drv_c = 64'd1; drv_last = 1'b1;
    @(posedge clk);
    #1 drv_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out", if8.Out, 64'd0);
    chk("midrst_count", 64'(if8.out_count), 64'd0);
    chk("midrst_out_valid", 64'(if8.out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    chk("midrst_in_ready", 64'(if8.in_ready), 64'd1);
    send(64'd1, 64'd0, 64'd0, 1'b1);
    take(0);

    // Zero triple still counts
    send(64'd0, 64'd0, 64'd0, 1'b1);
    take(0);

    // Counter saturation visible on the COUNT_W=2 instance
    for (int i = 0; i < 5; i++) send(64'd1, 64'd1, 64'd1, (i == 4));
    chk("sat_count_w2_const", 64'(if2.out_count), 64'd3);
    chk("sat_out_const", if2.Out, 64'd15);
    take(0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
